// File: rtl/blk_lock_ctrl.sv
// 10GBASE-R block-lock controller: checks 66b sync headers, declares or drops
// block lock, and drives the PMA bit-slip request until the block boundary aligns.
module blk_lock_ctrl #(
  parameter int SH_WIN     = 64,
  parameter int SH_INV_MAX = 16,
  parameter int SLIP_LEN   = 2,
  parameter int SLIP_WAIT  = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk_glbl,
  input  logic             rst_glbl_n,
  input  logic             rx_rdy,
  input  logic             hdr_vld,
  input  logic [1:0]       hdr,
  output logic             pma_slip,
  output logic             block_lock,
  output logic [CNT_W-1:0] slip_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt,
  input  logic             clr_cnt
);

  localparam int SH_W   = $clog2(SH_WIN + 1);
  localparam int INV_W  = $clog2(SH_INV_MAX + 1);
  localparam int SLIP_W = $clog2(SLIP_LEN + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_WIN_C    = SH_W'(SH_WIN);
  localparam logic [INV_W-1:0]  INV_MAX_C   = INV_W'(SH_INV_MAX);
  localparam logic [SLIP_W-1:0] SLIP_LAST_C = SLIP_W'(SLIP_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEST = 2'd1,
    ST_SLIP = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
  logic [SLIP_W-1:0]   slip_cyc_q, slip_cyc_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                pma_slip_q, pma_slip_d;
  logic                block_lock_q, block_lock_d;
  logic [CNT_W-1:0]    slip_cnt_q, slip_cnt_d;
  logic [CNT_W-1:0]    lock_loss_q, lock_loss_d;

  logic                hdr_inv_s;
  logic [SH_W-1:0]     sh_inc_s;
  logic [INV_W-1:0]    inv_inc_s;
  logic                slip_go_s;
  logic                lock_set_s;
  logic                lock_drop_s;

  assign hdr_inv_s = (hdr == 2'b00) || (hdr == 2'b11);
  assign sh_inc_s  = sh_cnt_q + SH_W'(1);
  assign inv_inc_s = inv_cnt_q + INV_W'(hdr_inv_s);

  // State and registered-output flops
  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      state_q      <= ST_IDLE;
      sh_cnt_q     <= '0;
      inv_cnt_q    <= '0;
      slip_cyc_q   <= '0;
      wait_cnt_q   <= '0;
      pma_slip_q   <= 1'b0;
      block_lock_q <= 1'b0;
      slip_cnt_q   <= '0;
      lock_loss_q  <= '0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      inv_cnt_q    <= inv_cnt_d;
      slip_cyc_q   <= slip_cyc_d;
      wait_cnt_q   <= wait_cnt_d;
      pma_slip_q   <= pma_slip_d;
      block_lock_q <= block_lock_d;
      slip_cnt_q   <= slip_cnt_d;
      lock_loss_q  <= lock_loss_d;
    end
  end

  // Next-state and window bookkeeping; decisions use the post-increment counts
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    inv_cnt_d   = inv_cnt_q;
    slip_cyc_d  = slip_cyc_q;
    wait_cnt_d  = wait_cnt_q;
    slip_go_s   = 1'b0;
    lock_set_s  = 1'b0;
    lock_drop_s = 1'b0;
    if (!rx_rdy) begin
      state_d     = ST_IDLE;
      sh_cnt_d    = '0;
      inv_cnt_d   = '0;
      slip_cyc_d  = '0;
      wait_cnt_d  = '0;
      lock_drop_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_TEST;
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
        end
        ST_TEST: begin
          if (hdr_vld) begin
            if (hdr_inv_s && !block_lock_q) begin
              slip_go_s = 1'b1;
            end else if (inv_inc_s == INV_MAX_C) begin
              slip_go_s   = 1'b1;
              lock_drop_s = 1'b1;
            end else if (sh_inc_s == SH_WIN_C) begin
              sh_cnt_d   = '0;
              inv_cnt_d  = '0;
              lock_set_s = (inv_inc_s == '0);
            end else begin
              sh_cnt_d  = sh_inc_s;
              inv_cnt_d = inv_inc_s;
            end
            if (slip_go_s) begin
              state_d    = ST_SLIP;
              sh_cnt_d   = '0;
              inv_cnt_d  = '0;
              slip_cyc_d = '0;
            end else begin
              state_d = ST_TEST;
            end
          end else begin
            state_d = ST_TEST;
          end
        end
        ST_SLIP: begin
          if (slip_cyc_q == SLIP_LAST_C) begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end else begin
            slip_cyc_d = slip_cyc_q + SLIP_W'(1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST_C) begin
            state_d   = ST_TEST;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output next values; clr_cnt overrides any same-cycle increment
  always_comb begin
    pma_slip_d   = (state_d == ST_SLIP);
    block_lock_d = block_lock_q;
    slip_cnt_d   = slip_cnt_q;
    lock_loss_d  = lock_loss_q;
    if (lock_drop_s) begin
      block_lock_d = 1'b0;
    end else if (lock_set_s) begin
      block_lock_d = 1'b1;
    end else begin
      block_lock_d = block_lock_q;
    end
    if (clr_cnt) begin
      slip_cnt_d  = '0;
      lock_loss_d = '0;
    end else begin
      if (slip_go_s && !(&slip_cnt_q)) begin
        slip_cnt_d = slip_cnt_q + CNT_W'(1);
      end else begin
        slip_cnt_d = slip_cnt_q;
      end
      if (lock_drop_s && block_lock_q && !(&lock_loss_q)) begin
        lock_loss_d = lock_loss_q + CNT_W'(1);
      end else begin
        lock_loss_d = lock_loss_q;
      end
    end
  end

  assign pma_slip      = pma_slip_q;
  assign block_lock    = block_lock_q;
  assign slip_cnt      = slip_cnt_q;
  assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_blk_lock_ctrl.sv
// Directed bench for blk_lock_ctrl; a second narrow-counter instance shares the
// stimulus so counter saturation can be reached in a short run.
module tb_blk_lock_ctrl;

  logic        clk_glbl = 1'b0;
  logic        rst_glbl_n;
  logic        rx_rdy;
  logic        hdr_vld;
  logic [1:0]  hdr;
  logic        clr_cnt;
  logic        pma_slip, block_lock;
  logic [15:0] slip_cnt, lock_loss_cnt;
  logic        s_pma_slip, s_block_lock;
  logic [3:0]  s_slip_cnt, s_lock_loss_cnt;
  logic        slip_seen;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk_glbl = ~clk_glbl;

  blk_lock_ctrl dut (
    .clk_glbl(clk_glbl), .rst_glbl_n(rst_glbl_n), .rx_rdy(rx_rdy),
    .hdr_vld(hdr_vld), .hdr(hdr), .pma_slip(pma_slip), .block_lock(block_lock),
    .slip_cnt(slip_cnt), .lock_loss_cnt(lock_loss_cnt), .clr_cnt(clr_cnt)
  );

  blk_lock_ctrl #(.CNT_W(4)) dut_sat (
    .clk_glbl(clk_glbl), .rst_glbl_n(rst_glbl_n), .rx_rdy(rx_rdy),
    .hdr_vld(hdr_vld), .hdr(hdr), .pma_slip(s_pma_slip), .block_lock(s_block_lock),
    .slip_cnt(s_slip_cnt), .lock_loss_cnt(s_lock_loss_cnt), .clr_cnt(clr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_glbl);
    #1;
    slip_seen = slip_seen | pma_slip;
  endtask

  initial begin
    rst_glbl_n = 1'b0; rx_rdy = 1'b0; hdr_vld = 1'b0; hdr = 2'b01; clr_cnt = 1'b0;
    slip_seen = 1'b0;
    tick(); tick();
    chk("rst_slip", pma_slip, 32'd0);
    chk("rst_lock", block_lock, 32'd0);
    chk("rst_slip_cnt", slip_cnt, 32'd0);
    chk("rst_loss_cnt", lock_loss_cnt, 32'd0);

    // First lock: 64 valid headers, one every other cycle
    rst_glbl_n = 1'b1; rx_rdy = 1'b1;
    tick();
    slip_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      hdr_vld = 1'b1; hdr = 2'b01;
      tick();
      hdr_vld = 1'b0;
      if (i == 62) chk("lock_early", block_lock, 32'd0);
      if (i == 63) chk("lock_64", block_lock, 32'd1);
      tick();
    end
    chk("no_slip_seen", slip_seen, 32'd0);
    chk("slip_cnt_0", slip_cnt, 32'd0);

    // Locked window with 15 invalid headers keeps lock
    for (int i = 0; i < 64; i++) begin
      hdr_vld = 1'b1; hdr = (i < 15) ? 2'b11 : 2'b01;
      tick();
    end
    chk("inv15_lock", block_lock, 32'd1);
    chk("inv15_loss", lock_loss_cnt, 32'd0);
    chk("inv15_noslip", pma_slip, 32'd0);
    hdr = 2'b11;
    tick();
    chk("win_reset_lock", block_lock, 32'd1);
    chk("win_reset_noslip", pma_slip, 32'd0);

    // Sixteenth invalid header lands on header #40 of this window
    for (int i = 2; i <= 40; i++) begin
      hdr = (i >= 26) ? 2'b11 : 2'b01;
      tick();
      if (i == 39) chk("inv15_of40_lock", block_lock, 32'd1);
    end
    hdr_vld = 1'b0;
    chk("inv16_lock", block_lock, 32'd0);
    chk("inv16_slip", pma_slip, 32'd1);
    chk("inv16_loss", lock_loss_cnt, 32'd1);
    chk("inv16_slip_cnt", slip_cnt, 32'd1);
    tick();
    chk("slip_cyc2", pma_slip, 32'd1);
    tick();
    chk("slip_end", pma_slip, 32'd0);
    hdr_vld = 1'b1; hdr = 2'b11;
    repeat (32) tick();
    hdr_vld = 1'b0;
    chk("wait_ignore_slip", pma_slip, 32'd0);
    chk("wait_ignore_cnt", slip_cnt, 32'd1);

    // Unlocked: fifth header invalid triggers slip
    for (int i = 0; i < 5; i++) begin
      hdr_vld = 1'b1; hdr = (i == 4) ? 2'b11 : 2'b01;
      tick();
      if (i == 3) chk("unl_valid_noslip", pma_slip, 32'd0);
    end
    hdr_vld = 1'b0;
    chk("unl_slip", pma_slip, 32'd1);
    chk("unl_slip_cnt", slip_cnt, 32'd2);
    chk("unl_lock", block_lock, 32'd0);
    tick();
    chk("unl_slip_cyc2", pma_slip, 32'd1);
    tick();
    chk("unl_slip_end", pma_slip, 32'd0);
    // Invalid headers through the hold-off, then valid ones back-to-back from
    // the first cycle headers are accepted again
    hdr_vld = 1'b1; hdr = 2'b11;
    repeat (32) tick();
    hdr = 2'b01;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 62) chk("b2b_lock_early", block_lock, 32'd0);
    end
    hdr_vld = 1'b0;
    chk("b2b_lock", block_lock, 32'd1);
    chk("b2b_slip_cnt", slip_cnt, 32'd2);

    // One-cycle rx_rdy drop while locked
    rx_rdy = 1'b0;
    tick();
    chk("rxrdy_lock", block_lock, 32'd0);
    chk("rxrdy_loss", lock_loss_cnt, 32'd2);
    chk("rxrdy_noslip", pma_slip, 32'd0);
    rx_rdy = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      hdr_vld = 1'b1; hdr = 2'b01;
      tick();
      hdr_vld = 1'b0;
      if (i == 62) chk("relock_early", block_lock, 32'd0);
      if (i == 63) chk("relock", block_lock, 32'd1);
      tick();
    end
    chk("relock_slip_cnt", slip_cnt, 32'd2);

    // Continuous invalid headers: 16 more slips, narrow counter saturates
    hdr_vld = 1'b1; hdr = 2'b11;
    repeat (556) tick();
    hdr_vld = 1'b0;
    chk("many_slip_cnt", slip_cnt, 32'd18);
    chk("sat_slip_cnt", s_slip_cnt, 32'hF);
    chk("many_loss_cnt", lock_loss_cnt, 32'd3);
    chk("sat_loss_cnt", s_lock_loss_cnt, 32'd3);

    // clr_cnt in the same cycle as a slip decision
    repeat (20) tick();
    hdr_vld = 1'b1; hdr = 2'b11; clr_cnt = 1'b1;
    tick();
    hdr_vld = 1'b0; clr_cnt = 1'b0;
    chk("clr_slip", pma_slip, 32'd1);
    chk("clr_slip_cnt", slip_cnt, 32'd0);
    chk("clr_sat_slip_cnt", s_slip_cnt, 32'd0);
    chk("clr_loss_cnt", lock_loss_cnt, 32'd0);

    // Asynchronous reset in the middle of the slip pulse
    rst_glbl_n = 1'b0;
    #1;
    chk("rst_mid_slip", pma_slip, 32'd0);
    chk("rst_mid_slip_sat", s_pma_slip, 32'd0);
    tick();
    chk("rst_mid_slip_cnt", slip_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
